// File: rtl/lane_rr_scheduler.sv
// Four-lane round-robin byte scheduler: grants one lane for a bounded burst,
// pops its bytes and registers them onto a single valid/ready output path.
module lane_rr_scheduler #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          MAX_BURST = 4,
  parameter logic [DATA_W-1:0]    IDLE_BYTE = 8'hBC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        valid,
  output logic [3:0]        ready_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        grant_id,
  output logic              busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int unsigned      CNT_W     = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic [0:0]        state_q,     state_d;
  logic [1:0]        rr_ptr_q,    rr_ptr_d;
  logic [1:0]        grant_id_q,  grant_id_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              valid_q,     valid_d;

  logic              slot_free;
  logic              lane_valid;
  logic              xfer;
  logic [DATA_W-1:0] lane_byte;
  logic              pick_found;
  logic [1:0]        pick_lane;
  logic [1:0]        idx;

  assign slot_free = !valid_q || out_ready;

  always_comb begin
    lane_byte  = in0;
    lane_valid = valid[grant_id_q];
    case (grant_id_q)
      2'd0:    lane_byte = in0;
      2'd1:    lane_byte = in1;
      2'd2:    lane_byte = in2;
      default: lane_byte = in3;
    endcase
  end

  // Pop strobe depends only on grant and output slot, never on valid.
  always_comb begin
    ready_in = '0;
    if (state_q == GRANT && slot_free) begin
      ready_in[grant_id_q] = 1'b1;
    end
  end

  assign xfer = |(ready_in & valid);

  // First valid lane at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_lane  = rr_ptr_q;
    idx        = rr_ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!pick_found && valid[idx]) begin
        pick_found = 1'b1;
        pick_lane  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d  = pick_lane;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      default: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = grant_id_q + 2'd1;
          end
        end else if (!lane_valid) begin
          state_d  = IDLE;
          rr_ptr_d = grant_id_q + 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = lane_byte;
      valid_d = 1'b1;
    end else if (out_ready && valid_q) begin
      data_d  = IDLE_BYTE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      data_q      <= IDLE_BYTE;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == GRANT);

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(ready_in));

  a_hold_on_stall : assert property (@(posedge clk) disable iff (reset)
    (valid_q && !out_ready) |=> ($stable(data_q) && valid_q));

endmodule

// File: doc/lane_rr_scheduler.md
Name: lane_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8-bit output byte path among four lane sources (in0..in3, valid[3:0]) feeding the physical-layer byte stream.
- Grants one lane at a time for a bounded burst and pops bytes from it with a per-lane ready strobe.
- Registers the selected byte onto a single output with valid/ready backpressure.
- Drives the IDLE_BYTE symbol on the output whenever no byte is held.

Parameters:
- DATA_W, 8: byte width of in0..in3 and data_out.
- MAX_BURST, 4: maximum bytes accepted per grant. Legal range is 1..15.
- IDLE_BYTE, 8'hBC: value driven on data_out when valid_out=0.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in0, input, DATA_W: lane 0 byte.
- in1, input, DATA_W: lane 1 byte.
- in2, input, DATA_W: lane 2 byte.
- in3, input, DATA_W: lane 3 byte.
- valid, input, 4: valid[i] means lane i presents a byte.
- ready_in, output, 4: pop strobe to lane i. A byte transfers when valid[i] & ready_in[i].
- out_ready, input, 1: downstream accepts data_out this cycle.
- data_out, output, DATA_W: registered output byte.
- valid_out, output, 1: data_out holds a real byte.
- grant_id, output, 2: currently granted lane.
- busy, output, 1: high when the FSM is in GRANT.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
  - valid_out=0, data_out=IDLE_BYTE, ready_in=4'b0000, busy=0.
  - An in-flight output byte is dropped.
- Output stage:
  - slot_free = !valid_out | out_ready.
  - On a lane transfer: data_out<=selected in_i and valid_out<=1 on the next edge.
  - Else, if out_ready & valid_out: valid_out<=0 and data_out<=IDLE_BYTE.
  - Else: hold.
  - data_out and valid_out never change while valid_out=1 and out_ready=0.
- ready_in[i] = (state==GRANT) & (grant_id==i) & slot_free. This is combinational and independent of valid[i]. At most one bit is ever high.
- FSM state IDLE:
  - If valid!=0, pick the first lane with valid high, searching from rr_ptr upward modulo 4 (wrap 3->0).
  - Load grant_id with that lane, clear burst_cnt, go to GRANT.
  - Otherwise stay in IDLE.
  - No transfers occur in IDLE.
- FSM state GRANT:
  - On each transfer, burst_cnt<=burst_cnt+1.
  - If the transfer occurs with burst_cnt==MAX_BURST-1: go to IDLE, rr_ptr<=grant_id+1 mod 4.
  - Else if valid[grant_id]==0 (no transfer this cycle): go to IDLE, rr_ptr<=grant_id+1 mod 4.
  - Else if slot_free=0: stall. Hold state, grant_id and burst_cnt. The grant is not released while stalled, even if other lanes are valid.
- grant_id keeps its last value while in IDLE.
- Latency: valid[i] rising in IDLE at cycle N gives GRANT at N+1 (ready_in[i]=1 if slot free) and data_out/valid_out at N+2.
- Release to re-grant costs exactly one IDLE bubble cycle. A lone valid lane is therefore re-granted after the bubble.
- valid[grant_id] dropping on the same cycle as the MAX_BURST-th transfer cannot occur, because that transfer requires valid high.
- Lanes that drop valid while not granted are simply skipped at the next search.
- Fairness: every continuously valid lane is granted within 3 other grants.

Test Plan:
- Lane 2 only, valid held for 6 bytes A0..A5, out_ready=1, MAX_BURST=4:
  - grant_id=2.
  - data_out A0..A3 on consecutive cycles.
  - one cycle with ready_in=0 (IDLE bubble).
  - re-grant lane 2, then A4, A5.
  - release; rr_ptr=3.
- All four lanes continuously valid, out_ready=1:
  - grant order 0,1,2,3,0.
  - exactly 4 bytes per grant, each grant separated by one bubble.
  - ready_in only ever one-hot or zero.
- Lane 1 granted, out_ready=0 for 3 cycles after the first byte:
  - data_out/valid_out held stable.
  - ready_in[1]=0, burst_cnt frozen.
  - after out_ready returns, the remaining 3 bytes follow back-to-back.
- Lane 0 valid for 1 byte then drops, lane 3 valid:
  - lane 0 releases after 1 byte.
  - next grant is lane 3 (search from rr_ptr=1 skips 1 and 2).
  - rr_ptr wraps to 0 after lane 3 releases.
- Reset asserted asynchronously mid-burst (lane 1, second byte):
  - outputs immediately return to reset values (valid_out=0, data_out=8'hBC).
  - after deassertion with lanes 1 and 2 valid, the first grant is lane 1 (rr_ptr=0).
- No valid for 10 cycles: busy=0, valid_out=0, data_out=8'hBC throughout.
